dmem_ctrl: RTL

Parametrised data-memory controller for the multi-cycle RISC-V datapath. It replaces the fixed-latency, 2-bit byte-enable data memory with a request/ready handshake and a configurable number of wait states. It performs full RV32 load/store width decoding (LB/LH/LW/LBU/LHU, SB/SH/SW), including sign and zero extension, and flags misaligned, illegal or out-of-range accesses. It sits between the core's load/store unit and the word-organised data RAM.

---
 rtl/dmem_ctrl_if.sv | 19 +
 rtl/dmem_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Load/store unit to data-memory controller handshake bundle.
interface dmem_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [2:0]      funct3;
    logic            ready;
    logic            fault;
    logic [XLEN-1:0] rdata;
    logic            busy;

    modport master (output req, we, addr, wdata, funct3,
                    input  ready, fault, rdata, busy);
    modport slave  (input  req, we, addr, wdata, funct3,
                    output ready, fault, rdata, busy);
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: RV32 load/store width decode, legality checks and
// a configurable wait-state handshake in front of a word-organised RAM.
module dmem_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       reset,
    dmem_ctrl_if.slave bus
);
    localparam int unsigned AW      = $clog2(DEPTH_WORDS);
    localparam int unsigned CW      = 4;
    localparam int unsigned NB      = XLEN / 8;
    localparam bit          NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt_q;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [1:0]      off_q;
    logic [XLEN-1:0] wdata_q;
    logic [2:0]      f3_q;
    logic            ready_q, fault_q, busy_q;
    logic [XLEN-1:0] rdata_q;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic            bad_c, commit_c;
    logic            op_we;
    logic [AW-1:0]   op_idx;
    logic [1:0]      op_off;
    logic [XLEN-1:0] op_wdata;
    logic [2:0]      op_f3;
    logic [XLEN-1:0] rword_c, ext_c, load_val_c, sdata_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [NB-1:0]   be_c;

    // Legality of the request currently presented on the bus
    always_comb begin
        bad_c = 1'b0;
        if (bus.funct3[1:0] == 2'b11)                              bad_c = 1'b1;
        if (bus.funct3[1:0] == 2'b01 && bus.addr[0])               bad_c = 1'b1;
        if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00)    bad_c = 1'b1;
        if (bus.funct3[2] && (bus.we || bus.funct3[1]))            bad_c = 1'b1;
        if (bus.addr[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS))          bad_c = 1'b1;
    end

    // With no wait states the access completes from the live bus, otherwise from the capture
    always_comb begin
        if (state == IDLE) begin
            op_we    = bus.we;
            op_idx   = bus.addr[AW+1:2];
            op_off   = bus.addr[1:0];
            op_wdata = bus.wdata;
            op_f3    = bus.funct3;
        end else begin
            op_we    = we_q;
            op_idx   = idx_q;
            op_off   = off_q;
            op_wdata = wdata_q;
            op_f3    = f3_q;
        end
        commit_c = reset && ((state == IDLE && bus.req && !bad_c && NO_WAIT) ||
                             (state == WAIT && cnt_q == CW'(1)));
    end

    // Lane extraction with sign/zero extension, and store lane steering
    always_comb begin
        rword_c = mem[op_idx];
        byte_c  = rword_c[{op_off, 3'b000} +: 8];
        half_c  = rword_c[{op_off[1], 4'b0000} +: 16];
        case (op_f3[1:0])
            2'b00:   ext_c = op_f3[2] ? {{(XLEN-8){1'b0}}, byte_c}
                                      : {{(XLEN-8){byte_c[7]}}, byte_c};
            2'b01:   ext_c = op_f3[2] ? {{(XLEN-16){1'b0}}, half_c}
                                      : {{(XLEN-16){half_c[15]}}, half_c};
            default: ext_c = rword_c;
        endcase
        load_val_c = op_we ? '0 : ext_c;

        case (op_f3[1:0])
            2'b00: begin
                be_c    = NB'(1) << op_off;
                sdata_c = {NB{op_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = NB'(3) << {op_off[1], 1'b0};
                sdata_c = {(NB/2){op_wdata[15:0]}};
            end
            default: begin
                be_c    = '1;
                sdata_c = op_wdata;
            end
        endcase
    end

    // RAM is never reset; writes happen only on the RESP-entry edge
    always_ff @(posedge clk) begin
        if (commit_c && op_we) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be_c[i]) mem[op_idx][8*i +: 8] <= sdata_c[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        idx_q   <= bus.addr[AW+1:2];
                        off_q   <= bus.addr[1:0];
                        wdata_q <= bus.wdata;
                        f3_q    <= bus.funct3;
                        busy_q  <= 1'b1;
                        if (bad_c) begin
                            state   <= RESP;
                            ready_q <= 1'b1;
                            fault_q <= 1'b1;
                            rdata_q <= '0;
                        end else if (NO_WAIT) begin
                            state   <= RESP;
                            ready_q <= 1'b1;
                            rdata_q <= load_val_c;
                        end else begin
                            state   <= WAIT;
                            cnt_q   <= CW'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= load_val_c;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.fault = fault_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
endmodule
